// File: rtl/cmp_result_fifo.sv
// Comparator result FIFO: encodes flag bundles into tagged entries, buffers them, and keeps saturating stats.
// Optional macro CMP_RESULT_CHECK_EN adds a reference 32-bit compare that flags wrong-but-consistent results.
module cmp_result_fifo #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       sign,
    input  logic [31:0]                op1,
    input  logic [31:0]                op2,
    input  logic                       eq,
    input  logic                       neq,
    input  logic                       grt,
    input  logic                       lss,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_code,
    output logic                       out_sign,
    output logic [SEQ_W-1:0]           out_seq,
    output logic [CNT_W-1:0]           cnt_eq,
    output logic [CNT_W-1:0]           cnt_grt,
    output logic [CNT_W-1:0]           cnt_lss,
    output logic [CNT_W-1:0]           cnt_err,
    output logic                       err_flag,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 3 + SEQ_W;

    typedef enum logic [1:0] {
        CODE_EQ  = 2'b00,
        CODE_GRT = 2'b01,
        CODE_LSS = 2'b10,
        CODE_ERR = 2'b11
    } code_t;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [SEQ_W-1:0] seq;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             consistent;
    code_t            code;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = out_ready && !empty;
    assign level     = wr_ptr - rd_ptr;

`ifdef CMP_RESULT_CHECK_EN
    logic  ref_lt;
    code_t ref_code;

    always_comb begin
        ref_lt = sign ? ($signed(op1) < $signed(op2)) : (op1 < op2);
        if (op1 == op2)
            ref_code = CODE_EQ;
        else if (ref_lt)
            ref_code = CODE_LSS;
        else
            ref_code = CODE_GRT;
    end
`else
    logic unused_ops;
    assign unused_ops = ^{op1, op2};
`endif

    // Exactly one outcome flag plus a complementary neq makes a trustworthy bundle.
    always_comb begin
        consistent = ((eq & !grt & !lss) | (!eq & grt & !lss) | (!eq & !grt & lss))
                     && (neq == !eq);
        if (!consistent)
            code = CODE_ERR;
        else if (eq)
            code = CODE_EQ;
        else if (grt)
            code = CODE_GRT;
        else
            code = CODE_LSS;
`ifdef CMP_RESULT_CHECK_EN
        if (consistent && (code != ref_code))
            code = CODE_ERR;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            seq    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                seq    <= seq + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {code, sign, seq};
    end

    // Head fields read as zero while empty so stale storage never leaks out.
    assign head     = mem[rd_ptr[AW-1:0]];
    assign out_code = empty ? 2'b00 : head[EW-1:EW-2];
    assign out_sign = !empty && head[SEQ_W];
    assign out_seq  = empty ? '0 : head[SEQ_W-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_eq   <= '0;
            cnt_grt  <= '0;
            cnt_lss  <= '0;
            cnt_err  <= '0;
            err_flag <= 1'b0;
        end else if (clr) begin
            cnt_eq   <= '0;
            cnt_grt  <= '0;
            cnt_lss  <= '0;
            cnt_err  <= '0;
            err_flag <= 1'b0;
        end else if (push) begin
            case (code)
                CODE_EQ:  if (cnt_eq  != '1) cnt_eq  <= cnt_eq  + 1'b1;
                CODE_GRT: if (cnt_grt != '1) cnt_grt <= cnt_grt + 1'b1;
                CODE_LSS: if (cnt_lss != '1) cnt_lss <= cnt_lss + 1'b1;
                default: begin
                    if (cnt_err != '1) cnt_err <= cnt_err + 1'b1;
                    err_flag <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_result_fifo.sv
// Scoreboard bench for cmp_result_fifo: driver queues expected entries, a negedge monitor checks every pop.
module tb_cmp_result_fifo;
    localparam int DEPTH = 8;
    localparam int SEQ_W = 4;
    localparam int CNT_W = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             sign = 1'b0;
    logic [31:0]      op1 = '0;
    logic [31:0]      op2 = '0;
    logic             eq = 1'b0;
    logic             neq = 1'b0;
    logic             grt = 1'b0;
    logic             lss = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [1:0]       out_code;
    logic             out_sign;
    logic [SEQ_W-1:0] out_seq;
    logic [CNT_W-1:0] cnt_eq;
    logic [CNT_W-1:0] cnt_grt;
    logic [CNT_W-1:0] cnt_lss;
    logic [CNT_W-1:0] cnt_err;
    logic             err_flag;
    logic [LW-1:0]    level;

    cmp_result_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .op1(op1), .op2(op2), .eq(eq), .neq(neq), .grt(grt), .lss(lss),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_sign(out_sign), .out_seq(out_seq), .cnt_eq(cnt_eq), .cnt_grt(cnt_grt),
        .cnt_lss(cnt_lss), .cnt_err(cnt_err), .err_flag(err_flag), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       code;
        logic             sign;
        logic [SEQ_W-1:0] seq;
    } exp_t;

    exp_t             exp_q[$];
    int               errors = 0;
    int               checks = 0;
    int               m_level = 0;
    logic [SEQ_W-1:0] m_seq = '0;
    int               m_eq = 0, m_grt = 0, m_lss = 0, m_err = 0;
    logic             m_flag = 1'b0;

    // Flag nibbles are {eq, neq, grt, lss}.
    localparam logic [3:0] F_EQ  = 4'b1000;
    localparam logic [3:0] F_GRT = 4'b0110;
    localparam logic [3:0] F_LSS = 4'b0101;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_state(input string tag);
        check_output({tag, "_in_ready"}, in_ready, m_level < DEPTH);
        check_output({tag, "_out_valid"}, out_valid, m_level > 0);
        check_output({tag, "_level"}, level, m_level);
        check_output({tag, "_cnt_eq"}, cnt_eq, m_eq);
        check_output({tag, "_cnt_grt"}, cnt_grt, m_grt);
        check_output({tag, "_cnt_lss"}, cnt_lss, m_lss);
        check_output({tag, "_cnt_err"}, cnt_err, m_err);
        check_output({tag, "_err_flag"}, err_flag, m_flag);
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic apply_stimulus(input logic v, input logic s, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] f, input logic rdy, input logic c, input logic [1:0] exp_code);
        logic acc;
        logic pp;
        in_valid = v; sign = s; op1 = a; op2 = b;
        {eq, neq, grt, lss} = f;
        out_ready = rdy; clr = c;
        acc = v && (m_level < DEPTH);
        pp  = rdy && (m_level > 0);
        if (acc) begin
            exp_q.push_back({exp_code, s, m_seq});
        end
        @(posedge clk);
        #1;
        m_level = m_level + int'(acc) - int'(pp);
        if (acc) m_seq = m_seq + 1'b1;
        if (c) begin
            m_eq = 0; m_grt = 0; m_lss = 0; m_err = 0; m_flag = 1'b0;
        end else if (acc) begin
            case (exp_code)
                2'b00: if (m_eq  < CMAX) m_eq++;
                2'b01: if (m_grt < CMAX) m_grt++;
                2'b10: if (m_lss < CMAX) m_lss++;
                default: begin
                    if (m_err < CMAX) m_err++;
                    m_flag = 1'b1;
                end
            endcase
        end
        in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, rdy, 1'b0, 2'b00);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && m_level > 0; i++) idle(1'b1);
    endtask

    // Every cycle the DUT offers a head that the consumer takes, it must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pop: got code %0h seq %0h expected no entry", out_code, out_seq);
            end else begin
                e = exp_q.pop_front();
                check_output("head_code", out_code, e.code);
                check_output("head_sign", out_sign, e.sign);
                check_output("head_seq", out_seq, e.seq);
            end
        end
    end

    initial begin
        #12;
        check_output("reset_in_ready", in_ready, 1);
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_level", level, 0);
        check_output("reset_out_code", out_code, 0);
        check_output("reset_out_seq", out_seq, 0);
        check_state("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1'b0);
        check_state("idle");

        // Equal operands, then pop the single entry.
        apply_stimulus(1'b1, 1'b0, 32'd5, 32'd5, F_EQ, 1'b0, 1'b0, 2'b00);
        check_output("eq_cnt_eq", cnt_eq, 1);
        check_output("eq_out_code", out_code, 2'b00);
        check_output("eq_out_seq", out_seq, 0);
        check_state("eq_push");
        idle(1'b1);
        check_state("eq_pop");

        // Fill to full, then pop+push while full only pops.
        for (int i = 0; i < DEPTH; i++)
            apply_stimulus(1'b1, 1'b1, 32'd9 + i, 32'd3, F_GRT, 1'b0, 1'b0, 2'b01);
        check_output("full_in_ready", in_ready, 0);
        check_output("full_level", level, DEPTH);
        check_state("full");
        apply_stimulus(1'b1, 1'b1, 32'd100, 32'd3, F_GRT, 1'b1, 1'b0, 2'b01);
        check_output("full_poppush_level", level, DEPTH - 1);
        check_state("full_poppush");
        for (int i = 0; i < DEPTH; i++)
            apply_stimulus(1'b1, 1'b0, 32'd50, 32'd7, F_GRT, 1'b1, 1'b0, 2'b01);
        check_state("wrap_stream");
        drain();
        check_state("wrap_drained");

        // Inconsistent flags, then clear racing an accept.
        apply_stimulus(1'b1, 1'b0, 32'd4, 32'd4, 4'b1010, 1'b0, 1'b0, 2'b11);
        check_output("err_cnt_err", cnt_err, 1);
        check_output("err_flag_set", err_flag, 1);
        check_output("err_out_code", out_code, 2'b11);
        check_state("err");
        apply_stimulus(1'b1, 1'b0, 32'd8, 32'd8, F_EQ, 1'b0, 1'b1, 2'b00);
        check_output("clr_cnt_eq", cnt_eq, 0);
        check_output("clr_cnt_err", cnt_err, 0);
        check_output("clr_err_flag", err_flag, 0);
        check_output("clr_level", level, 2);
        check_state("clr");
        apply_stimulus(1'b1, 1'b0, 32'd1, 32'd2, 4'b0001, 1'b1, 1'b0, 2'b11);
        apply_stimulus(1'b1, 1'b0, 32'd1, 32'd2, 4'b0000, 1'b1, 1'b0, 2'b11);
        apply_stimulus(1'b1, 1'b0, 32'd1, 32'd2, 4'b0111, 1'b1, 1'b0, 2'b11);
        check_state("inconsistent");
        drain();

        // Signed -1 vs 1 flagged grt is wrong; unsigned it is right.
`ifdef CMP_RESULT_CHECK_EN
        apply_stimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, F_GRT, 1'b0, 1'b0, 2'b11);
`else
        apply_stimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, F_GRT, 1'b0, 1'b0, 2'b01);
`endif
        apply_stimulus(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, F_GRT, 1'b0, 1'b0, 2'b01);
        check_state("ref_check");
        drain();

        // Saturate cnt_lss while streaming.
        for (int i = 0; i < 20; i++)
            apply_stimulus(1'b1, 1'b0, 32'd2, 32'd7 + i, F_LSS, 1'b1, 1'b0, 2'b10);
        check_output("sat_cnt_lss", cnt_lss, CMAX);
        check_state("sat");

        // Asynchronous reset with entries buffered.
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, 1'b0, 32'd2, 32'd9, F_LSS, 1'b0, 1'b0, 2'b10);
        check_output("pre_reset_level", level, 4);
        #2;
        resetn = 1'b0;
        #1;
        check_output("async_out_valid", out_valid, 0);
        check_output("async_level", level, 0);
        check_output("async_cnt_lss", cnt_lss, 0);
        exp_q.delete();
        m_level = 0; m_seq = '0;
        m_eq = 0; m_grt = 0; m_lss = 0; m_err = 0; m_flag = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        apply_stimulus(1'b1, 1'b0, 32'd3, 32'd3, F_EQ, 1'b0, 1'b0, 2'b00);
        check_output("post_reset_seq", out_seq, 0);
        check_state("post_reset");
        drain();
        check_output("scoreboard_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
